// File: rtl/tug_match_scorer.sv
// tug_match_scorer: match-level scorer for the tug-of-war game.
// Tracks the signed rope position, decodes the LED score word, counts
// games per player and flags the end of a best-of match.
// Optional feature macro: SCORER_CATCHUP_EN (catch-up double step from the
// outermost non-win position back toward centre on a proper push).
module tug_match_scorer #(
  parameter int SIDE_LEN  = 3,
  parameter int WIN_GAMES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winrnd,
  input  logic                  right,
  input  logic                  leds_on,
  input  logic                  tie,
  input  logic                  new_game,
  input  logic                  clear_score,
  output logic [2*SIDE_LEN:0]   score,
  output logic                  endrnd,
  output logic [3:0]            games_l,
  output logic [3:0]            games_r,
  output logic                  match_over,
  output logic                  match_right
);

  localparam int SW    = 2*SIDE_LEN + 1;
  localparam int POS_W = $clog2(SIDE_LEN + 2) + 1;
  localparam int WIN_I = SIDE_LEN + 1;

  localparam logic [SW-1:0] ONE_HOT = SW'(1);
  localparam logic [SW-1:0] WR_MASK = SW'((1 << SIDE_LEN) - 1);
  localparam logic [SW-1:0] WL_MASK = WR_MASK << (SIDE_LEN + 1);
  localparam logic [3:0]    WIN_G   = 4'(WIN_GAMES);

  logic signed [POS_W-1:0] pos;
  logic signed [POS_W-1:0] pos_nxt;
  int                      pos_i;
  int                      step_i;
  logic                    mr;
  logic                    move_ok;
  logic                    ng_ok;
  logic                    win_l_nxt;
  logic                    win_r_nxt;
  logic [3:0]              games_l_inc;
  logic [3:0]              games_r_inc;

  // Saturating game-counter increment; holds at WIN_GAMES
  function automatic logic [3:0] sat_inc(input logic [3:0] g);
    if (g >= WIN_G) return g;
    return g + 4'd1;
  endfunction

  // Move direction, qualifier, step size and next position
  always_comb begin
    pos_i   = int'(pos);
    mr      = ~(right ^ leds_on);
    move_ok = winrnd & ~tie & ~endrnd & ~match_over;
    ng_ok   = new_game & endrnd & ~match_over;
    step_i  = mr ? 1 : -1;
`ifdef SCORER_CATCHUP_EN
    if (leds_on && pos_i == SIDE_LEN && !mr)
      step_i = -2;
    else if (leds_on && pos_i == -SIDE_LEN && mr)
      step_i = 2;
`endif
    pos_nxt     = $signed(POS_W'(pos_i + step_i));
    win_r_nxt   = (pos_i + step_i == WIN_I);
    win_l_nxt   = (pos_i + step_i == -WIN_I);
    games_l_inc = sat_inc(games_l);
    games_r_inc = sat_inc(games_r);
  end

  // Position, game counters and match status; clear > new_game > move
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos         <= '0;
      games_l     <= '0;
      games_r     <= '0;
      match_over  <= 1'b0;
      match_right <= 1'b0;
    end else if (clear_score) begin
      pos         <= '0;
      games_l     <= '0;
      games_r     <= '0;
      match_over  <= 1'b0;
      match_right <= 1'b0;
    end else if (ng_ok) begin
      pos <= '0;
    end else if (move_ok) begin
      pos <= pos_nxt;
      if (win_r_nxt) begin
        games_r <= games_r_inc;
        if (games_r_inc == WIN_G) begin
          match_over  <= 1'b1;
          match_right <= 1'b1;
        end
      end
      if (win_l_nxt) begin
        games_l <= games_l_inc;
        if (games_l_inc == WIN_G) begin
          match_over  <= 1'b1;
          match_right <= 1'b0;
        end
      end
    end
  end

  // Moore decode of the LED word and the win flag from the position
  always_comb begin
    endrnd = (int'(pos) == WIN_I) || (int'(pos) == -WIN_I);
    if (int'(pos) == WIN_I)
      score = WR_MASK;
    else if (int'(pos) == -WIN_I)
      score = WL_MASK;
    else
      score = ONE_HOT << unsigned'(SIDE_LEN - int'(pos));
  end

endmodule

// File: tb/tb_tug_match_scorer.sv
// Directed bench for tug_match_scorer (SIDE_LEN=3, WIN_GAMES=2) with a
// scoreboard queue of expected outputs.
module tb_tug_match_scorer;

  logic       clk = 1'b0;
  logic       rst;
  logic       winrnd, right, leds_on, tie, new_game, clear_score;
  logic [6:0] score;
  logic       endrnd;
  logic [3:0] games_l, games_r;
  logic       match_over, match_right;

  typedef struct packed {
    logic [6:0] score;
    logic       endrnd;
    logic [3:0] gl;
    logic [3:0] gr;
    logic       mo;
    logic       mr;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  tug_match_scorer #(.SIDE_LEN(3), .WIN_GAMES(2)) dut (
    .clk(clk), .rst(rst), .winrnd(winrnd), .right(right), .leds_on(leds_on),
    .tie(tie), .new_game(new_game), .clear_score(clear_score),
    .score(score), .endrnd(endrnd), .games_l(games_l), .games_r(games_r),
    .match_over(match_over), .match_right(match_right)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_push(input logic [6:0] s, input logic e, input logic [3:0] gl,
                             input logic [3:0] gr, input logic mo, input logic mr);
    exp_t x;
    x.score = s; x.endrnd = e; x.gl = gl; x.gr = gr; x.mo = mo; x.mr = mr;
    sb.push_back(x);
  endtask

  task automatic compare(input string tag);
    exp_t x;
    if (sb.size() == 0) begin
      total++; bad++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
      return;
    end
    x = sb.pop_front();
    chk({tag, ".score"},  {1'b0, score},  {1'b0, x.score});
    chk({tag, ".endrnd"}, {7'b0, endrnd}, {7'b0, x.endrnd});
    chk({tag, ".gl"},     {4'b0, games_l}, {4'b0, x.gl});
    chk({tag, ".gr"},     {4'b0, games_r}, {4'b0, x.gr});
    chk({tag, ".mo"},     {7'b0, match_over},  {7'b0, x.mo});
    chk({tag, ".mr"},     {7'b0, match_right}, {7'b0, x.mr});
  endtask

  // One clocked step: drive inputs, queue expectation, sample after the edge
  task automatic step(input string tag, input logic w, input logic r, input logic l,
                      input logic t, input logic ng, input logic cs,
                      input logic [6:0] s, input logic e, input logic [3:0] gl,
                      input logic [3:0] gr, input logic mo, input logic mr);
    @(negedge clk);
    winrnd = w; right = r; leds_on = l; tie = t; new_game = ng; clear_score = cs;
    expect_push(s, e, gl, gr, mo, mr);
    @(posedge clk);
    #1;
    winrnd = 0; tie = 0; new_game = 0; clear_score = 0;
    compare(tag);
  endtask

  initial begin
    rst = 1; winrnd = 0; right = 0; leds_on = 0; tie = 0; new_game = 0; clear_score = 0;
    repeat (2) @(posedge clk);
    #1;
    expect_push(7'b0001000, 0, 0, 0, 0, 0);
    compare("reset");
    @(negedge clk);
    rst = 0;

    // Right walks to a win, then a pulse in the win state is absorbed
    step("r1",  1, 1, 1, 0, 0, 0, 7'b0000100, 0, 0, 0, 0, 0);
    step("r2",  1, 1, 1, 0, 0, 0, 7'b0000010, 0, 0, 0, 0, 0);
    step("r3",  1, 1, 1, 0, 0, 0, 7'b0000001, 0, 0, 0, 0, 0);
    step("wr",  1, 1, 1, 0, 0, 0, 7'b0000111, 1, 0, 1, 0, 0);
    step("wr5", 1, 1, 1, 0, 0, 0, 7'b0000111, 1, 0, 1, 0, 0);
    step("ng1", 0, 1, 1, 0, 1, 0, 7'b0001000, 0, 0, 1, 0, 0);

    // Tie suppresses the move at R1
    step("r1b", 1, 1, 1, 0, 0, 0, 7'b0000100, 0, 0, 1, 0, 0);
    step("tie", 1, 1, 1, 1, 0, 0, 7'b0000100, 0, 0, 1, 0, 0);

    // Jumped lights move the other way, out to L3
    step("j0",  1, 1, 0, 0, 0, 0, 7'b0001000, 0, 0, 1, 0, 0);
    step("j1",  1, 1, 0, 0, 0, 0, 7'b0010000, 0, 0, 1, 0, 0);
    step("j2",  1, 1, 0, 0, 0, 0, 7'b0100000, 0, 0, 1, 0, 0);
    step("j3",  1, 1, 0, 0, 0, 0, 7'b1000000, 0, 0, 1, 0, 0);
`ifdef SCORER_CATCHUP_EN
    step("cu",  1, 1, 1, 0, 0, 0, 7'b0010000, 0, 0, 1, 0, 0);
    step("l2",  1, 0, 1, 0, 0, 0, 7'b0100000, 0, 0, 1, 0, 0);
`else
    step("cu",  1, 1, 1, 0, 0, 0, 7'b0100000, 0, 0, 1, 0, 0);
`endif
    step("l3",  1, 0, 1, 0, 0, 0, 7'b1000000, 0, 0, 1, 0, 0);
    step("wl",  1, 0, 1, 0, 0, 0, 7'b1110000, 1, 1, 1, 0, 0);

    // new_game together with winrnd: round discarded, back to neutral
    step("ngw", 1, 1, 1, 0, 1, 0, 7'b0001000, 0, 1, 1, 0, 0);

    // Right wins the match
    step("m1",  1, 1, 1, 0, 0, 0, 7'b0000100, 0, 1, 1, 0, 0);
    step("m2",  1, 1, 1, 0, 0, 0, 7'b0000010, 0, 1, 1, 0, 0);
    step("m3",  1, 1, 1, 0, 0, 0, 7'b0000001, 0, 1, 1, 0, 0);
    step("mw",  1, 1, 1, 0, 0, 0, 7'b0000111, 1, 1, 2, 1, 1);
    step("ngx", 0, 1, 1, 0, 1, 0, 7'b0000111, 1, 1, 2, 1, 1);
    step("mvx", 1, 0, 1, 0, 0, 0, 7'b0000111, 1, 1, 2, 1, 1);

    // clear_score wins over a simultaneous new_game
    step("clr", 0, 1, 1, 0, 1, 1, 7'b0001000, 0, 0, 0, 0, 0);

    // Left wins a game, next game, then walk to L2
    step("a1",  1, 0, 1, 0, 0, 0, 7'b0010000, 0, 0, 0, 0, 0);
    step("a2",  1, 0, 1, 0, 0, 0, 7'b0100000, 0, 0, 0, 0, 0);
    step("a3",  1, 0, 1, 0, 0, 0, 7'b1000000, 0, 0, 0, 0, 0);
    step("aw",  1, 0, 1, 0, 0, 0, 7'b1110000, 1, 1, 0, 0, 0);
    step("ng2", 0, 0, 1, 0, 1, 0, 7'b0001000, 0, 1, 0, 0, 0);
    step("b1",  1, 0, 1, 0, 0, 0, 7'b0010000, 0, 1, 0, 0, 0);
    step("b2",  1, 0, 1, 0, 0, 0, 7'b0100000, 0, 1, 0, 0, 0);

    // Asynchronous reset mid-cycle, observed before the next edge
    @(negedge clk);
    #1;
    rst = 1;
    #1;
    expect_push(7'b0001000, 0, 0, 0, 0, 0);
    compare("arst");
    @(negedge clk);
    rst = 0;

    step("post", 1, 1, 1, 0, 0, 0, 7'b0000100, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tug_match_scorer.md
# tug_match_scorer

Parametrised match-level scorer for the tug-of-war game. It tracks the rope position across a configurable number of positions per side and converts each round result into a one-step move. It also counts games won by each player and flags the end of a best-of match. It sits downstream of the push-button/round logic (consumes `winrnd`, `right`, `leds_on`, `tie`) and drives the LED score display and match status.

## Interface
Parameters:
- `SIDE_LEN`, 3, non-winning positions per side (≥2); score width = 2·SIDE_LEN+1
- `WIN_GAMES`, 2, games needed to win the match (1..15)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `winrnd`  in  1  one-cycle pulse: a round was decided
- `right`  in  1  1 = right player pushed first
- `leds_on`  in  1  1 = lights were on (proper push); 0 = jumped the light
- `tie`  in  1  round tied; suppresses the move
- `new_game`  in  1  one-cycle pulse: start next game after a game win
- `clear_score`  in  1  synchronous match clear
- `score`  out  2·SIDE_LEN+1  LED word, MSB = far left
- `endrnd`  out  1  high while position is a win
- `games_l`, `games_r`  out  4 each  games won by each player
- `match_over`  out  1  a player reached WIN_GAMES
- `match_right`  out  1  valid when match_over; 1 = right won match

## Operation
- Position register `pos` is signed, range −(SIDE_LEN+1)..+(SIDE_LEN+1).
  - 0 = neutral; +k = R_k; −k = L_k.
  - ±(SIDE_LEN+1) = WR/WL win states.
- Move direction: `mr = ~(right ^ leds_on)`. mr=1 moves +1 (right), mr=0 moves −1.
- Move qualifier: `winrnd & ~tie & ~endrnd & ~match_over`. Otherwise `pos` holds.
- Win states are absorbing until `new_game` or `clear_score`.
- Entering a win increments `games_l` or `games_r` exactly once, on the same edge. Counters saturate at WIN_GAMES.
- `match_over` and `match_right` are set on the edge a counter reaches WIN_GAMES. They stay set until `clear_score`.
- `new_game` acts only when `endrnd=1` and `match_over=0`: `pos` returns to 0 and counters are kept. In any other condition it is ignored.
- `clear_score` sets `pos`=0, both counters=0, `match_over`=0 and `match_right`=0.
- Priority: `clear_score` > `new_game` > move.
- Score decode (Moore, combinational from `pos`):
  - neutral: bit SIDE_LEN.
  - L_k: bit SIDE_LEN+k.
  - R_k: bit SIDE_LEN−k.
  - WL: top SIDE_LEN bits set.
  - WR: bottom SIDE_LEN bits set.
  - Example, SIDE_LEN=3: neutral 0001000, WL 1110000, WR 0000111.
- `endrnd` = (|pos| == SIDE_LEN+1).
- No error state exists; `pos` is unreachable outside its range by construction.

## Timing
- Reset values: `pos`=0, `score` = neutral one-hot, `endrnd`=0, `games_l`=`games_r`=0, `match_over`=0, `match_right`=0.
- Reset takes effect immediately, including mid-game or in a win state.
- `winrnd` sampled at edge n: `score`/`endrnd` reflect the new position after edge n (1-cycle latency). Counters and `match_over` update on the same edge.
- `winrnd` held high for several cycles moves once per cycle. Upstream guarantees single-cycle pulses.
- `winrnd` and `tie` high together: no move.
- `new_game` and `winrnd` in the same cycle while in a win: `pos` goes to 0 and the round is discarded.

## Configuration
- `SCORER_CATCHUP_EN` defined: catch-up rule active.
  - Applies when `leds_on=1` and `pos` = ±SIDE_LEN (outermost non-win).
  - A move toward centre steps 2 positions: L_SIDE_LEN→L_(SIDE_LEN−2), R_SIDE_LEN→R_(SIDE_LEN−2).
  - All other moves step 1.
- Not defined: every move steps exactly 1.

## Test plan
- Reset (SIDE_LEN=3) -> `score`=0001000, `endrnd`=0, counters 0, `match_over`=0.
- Four pulses with right=1, leds_on=1 -> score 0000100, 0000010, 0000001, 0000111.
  - On the last: `endrnd`=1, `games_r`=1.
  - A 5th pulse -> unchanged, `games_r` still 1.
- Three pulses with right=1, leds_on=0 (jump) -> L3 (1000000). Then right=1, leds_on=1:
  - Macro defined -> 0010000 (L1).
  - Macro not defined -> 0100000 (L2).
- Pulse `winrnd` with `tie`=1 at R1 -> score stays 0000100, no counter change.
- WIN_GAMES=2:
  - Right wins, `new_game` -> 0001000, `games_r`=1.
  - Right wins again -> `games_r`=2, `match_over`=1, `match_right`=1.
  - `new_game` -> ignored.
  - `clear_score` -> neutral, counters 0, `match_over`=0.
- Assert `rst` asynchronously mid-cycle at L2 with `games_l`=1 -> outputs return to reset values before the next clock edge.
